// File: rtl/nes_joypad_ctrl.sv
// NES standard-controller emulation: maps a USB HID keycode to button state and
// serves it through the $4016 strobe/serial-read protocol.
module nes_joypad_ctrl #(
   parameter int unsigned HOLD_CYCLES = 500000,
   parameter logic [7:0]  KEY_A       = 8'h0E,
   parameter logic [7:0]  KEY_B       = 8'h0D,
   parameter logic [7:0]  KEY_SELECT  = 8'h2B,
   parameter logic [7:0]  KEY_START   = 8'h28,
   parameter logic [7:0]  KEY_UP      = 8'h1A,
   parameter logic [7:0]  KEY_DOWN    = 8'h16,
   parameter logic [7:0]  KEY_LEFT    = 8'h04,
   parameter logic [7:0]  KEY_RIGHT   = 8'h07
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] keycode,
   input  logic       strobe_we,
   input  logic       strobe_data,
   input  logic       rd_en,
   output logic       rd_data,
   output logic [7:0] buttons
);

   localparam int unsigned HW = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   logic [7:0]    dec;
   logic [7:0]    btn_q;
   logic [HW-1:0] hold_cnt;
   logic          strobe_q;
   logic [7:0]    sh_q;

   // If-chain order gives the lowest bit index priority on colliding keys.
   always_comb begin
      dec = '0;
      if (keycode != '0) begin
         if      (keycode == KEY_A)      dec = 8'h01;
         else if (keycode == KEY_B)      dec = 8'h02;
         else if (keycode == KEY_SELECT) dec = 8'h04;
         else if (keycode == KEY_START)  dec = 8'h08;
         else if (keycode == KEY_UP)     dec = 8'h10;
         else if (keycode == KEY_DOWN)   dec = 8'h20;
         else if (keycode == KEY_LEFT)   dec = 8'h40;
         else if (keycode == KEY_RIGHT)  dec = 8'h80;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_q    <= '0;
         hold_cnt <= '0;
      end else if (dec != '0) begin
         btn_q    <= dec;
         hold_cnt <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HW'(1);
      end else begin
         btn_q    <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q <= 1'b0;
      end else if (strobe_we) begin
         strobe_q <= strobe_data;
      end
   end

   // Reload keys off the old strobe_q, so a 1->0 write still captures btn_q once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q <= '1;
      end else if (strobe_q) begin
         sh_q <= btn_q;
      end else if (rd_en && !strobe_we) begin
         sh_q <= {1'b1, sh_q[7:1]};
      end
   end

   assign rd_data = strobe_q ? btn_q[0] : sh_q[0];
   assign buttons = btn_q;

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Directed bench for nes_joypad_ctrl: one instance with a short hold, one with hold disabled.
module tb_nes_joypad_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] keycode;
   logic       strobe_we;
   logic       strobe_data;
   logic       rd_en;
   logic       rd_data, rd_data0;
   logic [7:0] buttons, buttons0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   nes_joypad_ctrl #(.HOLD_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .keycode(keycode), .strobe_we(strobe_we),
      .strobe_data(strobe_data), .rd_en(rd_en), .rd_data(rd_data), .buttons(buttons)
   );

   nes_joypad_ctrl #(.HOLD_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .keycode(keycode), .strobe_we(strobe_we),
      .strobe_data(strobe_data), .rd_en(rd_en), .rd_data(rd_data0), .buttons(buttons0)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic d);
      strobe_we   = 1'b1;
      strobe_data = d;
      tick();
      strobe_we   = 1'b0;
      strobe_data = 1'b0;
   endtask

   task automatic latch();
      strobe(1'b1);
      strobe(1'b0);
   endtask

   // Bus samples the current bit in the rd_en cycle, shift happens at the edge.
   task automatic do_read(input string tag, input logic exp);
      rd_en = 1'b1;
      chk(tag, {7'b0, rd_data}, {7'b0, exp});
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; keycode = '0; strobe_we = 1'b0; strobe_data = 1'b0; rd_en = 1'b0;
      tick(); tick();
      chk("rst_buttons", buttons, 8'h00);
      chk("rst_rd_data", {7'b0, rd_data}, 8'h01);
      reset_n = 1'b1;
      tick();

      // A button, full 10-read sequence
      keycode = 8'h0E;
      tick();
      chk("a_buttons", buttons, 8'h01);
      latch();
      do_read("a_rd1", 1'b1);
      for (int i = 2; i <= 8; i++) do_read($sformatf("a_rd%0d", i), 1'b0);
      do_read("a_rd9", 1'b1);
      do_read("a_rd10", 1'b1);

      // Hold and release of Right
      keycode = 8'h07;
      tick();
      chk("right_buttons", buttons, 8'h80);
      keycode = 8'h00;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("hold_c%0d", i), buttons, 8'h80);
      end
      tick();
      chk("hold_release", buttons, 8'h00);
      keycode = 8'h07;
      tick();
      keycode = 8'h00;
      tick();
      chk("hold_again", buttons, 8'h80);
      keycode = 8'h1A;
      tick();
      chk("switch_up", buttons, 8'h10);

      // Strobe held high, hold disabled instance, A toggling with reads
      strobe(1'b1);
      for (int i = 0; i < 4; i++) begin
         keycode = (i % 2 == 0) ? 8'h0E : 8'h00;
         rd_en = 1'b1;
         tick();
         chk($sformatf("tog_btn%0d", i), buttons0, (i % 2 == 0) ? 8'h01 : 8'h00);
         chk($sformatf("tog_rd%0d", i), {7'b0, rd_data0}, (i % 2 == 0) ? 8'h01 : 8'h00);
      end
      rd_en = 1'b0;
      keycode = 8'h0E;
      tick();
      strobe(1'b0);
      do_read("tog_after_rd1", 1'b1);
      do_read("tog_after_rd2", 1'b0);

      // Start latched, keycode changes mid-sequence
      keycode = 8'h28;
      tick();
      chk("start_buttons", buttons, 8'h08);
      latch();
      do_read("st_rd1", 1'b0);
      do_read("st_rd2", 1'b0);
      keycode = 8'h0E;
      tick();
      chk("st_new_buttons", buttons, 8'h01);
      do_read("st_rd3", 1'b0);
      do_read("st_rd4", 1'b1);
      for (int i = 5; i <= 8; i++) do_read($sformatf("st_rd%0d", i), 1'b0);
      latch();
      do_read("st_relatch_rd1", 1'b1);

      // Simultaneous rd_en and strobe_we
      keycode = 8'h1A;
      tick();
      latch();
      do_read("sim_rd1", 1'b0);
      do_read("sim_rd2", 1'b0);
      rd_en = 1'b1; strobe_we = 1'b1; strobe_data = 1'b0;
      tick();
      rd_en = 1'b0; strobe_we = 1'b0;
      do_read("sim_rd3", 1'b0);
      do_read("sim_rd4", 1'b0);
      do_read("sim_rd5", 1'b1);
      keycode = 8'h0E;
      tick();
      chk("sim_sh_kept", {7'b0, rd_data}, 8'h00);
      rd_en = 1'b1; strobe_we = 1'b1; strobe_data = 1'b1;
      tick();
      rd_en = 1'b0; strobe_we = 1'b0; strobe_data = 1'b0;
      chk("sim_strobe1", {7'b0, rd_data}, 8'h01);
      strobe(1'b0);
      do_read("sim_after_rd1", 1'b1);

      // Reset mid-sequence
      latch();
      do_read("rs_rd1", 1'b1);
      do_read("rs_rd2", 1'b0);
      do_read("rs_rd3", 1'b0);
      reset_n = 1'b0;
      #1;
      chk("rs_buttons", buttons, 8'h00);
      chk("rs_rd_data", {7'b0, rd_data}, 8'h01);
      keycode = 8'h16;
      #1;
      reset_n = 1'b1;
      tick();
      chk("rs_down_buttons", buttons, 8'h20);
      chk("rs_no_strobe", {7'b0, rd_data}, 8'h01);
      latch();
      for (int i = 1; i <= 5; i++) do_read($sformatf("rs_d_rd%0d", i), 1'b0);
      do_read("rs_d_rd6", 1'b1);
      do_read("rs_d_rd7", 1'b0);
      do_read("rs_d_rd8", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
